// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretcher
// Purpose  : Turns single-cycle event pulses into level assertions with a
//            guaranteed minimum active width (HIGH_CYC) and a guaranteed
//            minimum inactive gap (LOW_CYC). Events that arrive while an
//            assertion or gap is in progress are counted in a saturating
//            queue and replayed back-to-back.
//
// Parameters
//   HIGH_CYC : output active width in cycles (>= 1)
//   LOW_CYC  : minimum inactive gap between assertions in cycles (>= 1)
//   QDEPTH   : maximum number of queued events (>= 1)
//   PE       : output polarity, 1 = active-high Y, 0 = active-low Y
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active low
//   I        in   event pulse, every high cycle is one event
//   clr_ovf  in   synchronous clear of the sticky overflow flag
//   Y        out  stretched level output (polarity per PE)
//   busy     out  high whenever the block is not idle
//   pending  out  number of queued events
//   ovf      out  sticky flag, set when an event is dropped at full queue
//
// Optional feature macro
//   PULSE_STRETCH_RETRIG_EN : when defined, an event during the active phase
//                             re-arms the active width instead of queueing.
//
// Revision : 1.0  initial release
// ============================================================================
module pulse_stretcher #(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 2,
    parameter int QDEPTH   = 3,
    parameter int PE       = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            I,
    input  logic                            clr_ovf,
    output logic                            Y,
    output logic                            busy,
    output logic [$clog2(QDEPTH+1)-1:0]     pending,
    output logic                            ovf
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    // Counter only ever holds values up to c_CNT_MAX-1.
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_PEND_W  = $clog2(QDEPTH + 1);

    localparam logic [c_CNT_W-1:0]  c_HIGH_LOAD = c_CNT_W'(HIGH_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_LOW_LOAD  = c_CNT_W'(LOW_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PEND_W-1:0] c_QFULL     = c_PEND_W'(QDEPTH);
    localparam logic [c_PEND_W-1:0] c_PEND_ONE  = c_PEND_W'(1);
    localparam logic                c_Y_ON      = (PE != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HIGH = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    // ------------------------------------------------------------------------
    // Parameter sanity checks (elaboration time)
    // ------------------------------------------------------------------------
    generate
        if (HIGH_CYC < 1) begin : g_bad_high_cyc
            $error("pulse_stretcher: HIGH_CYC must be >= 1");
        end
        if (LOW_CYC < 1) begin : g_bad_low_cyc
            $error("pulse_stretcher: LOW_CYC must be >= 1");
        end
        if (QDEPTH < 1) begin : g_bad_qdepth
            $error("pulse_stretcher: QDEPTH must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_PEND_W-1:0] r_pend;
    logic                r_ovf;

    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_deq;        // launch served from the queue
    logic                w_evt_taken;  // current event consumed directly
    logic                w_enq;        // current event must be queued
    logic                w_full;       // no room for a new event this edge
    logic                w_inc;
    logic                w_drop;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_deq       = 1'b0;
        w_evt_taken = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (I) begin
                    w_state_nxt = c_ST_HIGH;
                    w_cnt_nxt   = c_HIGH_LOAD;
                    w_evt_taken = 1'b1;
                end
            end

            c_ST_HIGH: begin
`ifdef PULSE_STRETCH_RETRIG_EN
                // Re-arm: the assertion lasts HIGH_CYC cycles past the
                // most recent event, even if the width was about to expire.
                if (I) begin
                    w_cnt_nxt   = c_HIGH_LOAD;
                    w_evt_taken = 1'b1;
                end else
`endif
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    w_state_nxt = c_ST_GAP;
                    w_cnt_nxt   = c_LOW_LOAD;
                end
            end

            c_ST_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else if (r_pend != '0) begin
                    // Queued events are older than the current input, so
                    // they launch first; the input (if any) queues behind.
                    w_state_nxt = c_ST_HIGH;
                    w_cnt_nxt   = c_HIGH_LOAD;
                    w_deq       = 1'b1;
                end else if (I) begin
                    // Empty queue at the launch point: the event launches
                    // directly rather than round-tripping through the queue.
                    w_state_nxt = c_ST_HIGH;
                    w_cnt_nxt   = c_HIGH_LOAD;
                    w_evt_taken = 1'b1;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------------
    // A simultaneous dequeue frees a slot, so a full queue still accepts the
    // event on a launch edge and the count stays unchanged.
    assign w_enq  = I & ~w_evt_taken;
    assign w_full = (r_pend == c_QFULL) & ~w_deq;
    assign w_inc  = w_enq & ~w_full;
    assign w_drop = w_enq & w_full;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            case ({w_inc, w_deq})
                2'b10:   r_pend <= r_pend + c_PEND_ONE;
                2'b01:   r_pend <= r_pend - c_PEND_ONE;
                default: r_pend <= r_pend;
            endcase
        end
    end

    // Setting wins over clearing so a drop on the clearing edge is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of registered state, no path from I
    // ------------------------------------------------------------------------
    assign Y       = (r_state == c_ST_HIGH) ? c_Y_ON : ~c_Y_ON;
    assign busy    = (r_state != c_ST_IDLE);
    assign pending = r_pend;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event pulses, such as those produced by the edge-detect pulser on button inputs, back into level signals of guaranteed minimum high and low width. Each accepted pulse produces exactly one output assertion of HIGH_CYC cycles, followed by at least LOW_CYC inactive cycles. Pulses that arrive while an assertion is in progress are queued in a saturating counter. The block sits between event logic and slow or level-sensitive consumers: LEDs, a downstream pulser, or handshake lines into another clock-agnostic module.

## Interface
- HIGH_CYC, 4: output active width in cycles; must be ≥1
- LOW_CYC, 2: minimum inactive gap between assertions in cycles; must be ≥1
- QDEPTH, 3: maximum queued pulses; must be ≥1
- PE, 1: output polarity; 1 = active-high Y, 0 = active-low Y
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- I  in  1  event pulse; each high cycle counts as one event
- clr_ovf  in  1  synchronous clear of ovf
- Y  out  1  stretched level output, polarity per PE
- busy  out  1  high when state ≠ IDLE
- pending  out  $clog2(QDEPTH+1)  number of queued events
- ovf  out  1  sticky flag; set when an event is dropped at full queue

## Operation
- States: IDLE, HIGH, GAP. Down-counter cnt is sized for max(HIGH_CYC, LOW_CYC).
- IDLE:
  - I=1: go to HIGH, cnt←HIGH_CYC-1.
  - I=0: stay in IDLE.
- HIGH:
  - cnt≠0: cnt decrements.
  - cnt=0: go to GAP, cnt←LOW_CYC-1.
- GAP:
  - cnt≠0: cnt decrements.
  - cnt=0 with pending>0: go to HIGH, cnt←HIGH_CYC-1, pending decrements.
  - cnt=0 with pending=0 and I=1: go to HIGH directly; the event is consumed, not queued.
  - Otherwise: go to IDLE.
- I=1 in HIGH or GAP, except at the GAP launch point above: pending increments.
  - If pending=QDEPTH, pending holds and ovf←1.
- Launch from GAP with pending>0 and I=1 on the same edge: one decrement and one increment, so pending is unchanged.
- ovf: set has priority over clr_ovf on the same edge.
- Y: asserted (1 if PE=1, 0 if PE=0) iff state=HIGH; otherwise at the inactive level. Y is a registered-state decode with no combinational path from I.

## Timing
- Reset (rst=0): state=IDLE, cnt=0, pending=0, ovf=0, busy=0, Y=inactive (0 if PE=1, 1 if PE=0). All take effect immediately (asynchronous), including mid-operation; queued events are discarded.
- Latency: I sampled high at edge k from IDLE → Y active after edge k, through edge k+HIGH_CYC; inactive after edge k+HIGH_CYC.
- Back-to-back assertion period: exactly HIGH_CYC+LOW_CYC cycles. LOW_CYC is never shortened.
- busy falls after edge k+HIGH_CYC+LOW_CYC for a lone pulse.
- pending and ovf update on the same edge as the event that changes them.

## Configuration
- PULSE_STRETCH_RETRIG_EN:
  - Defined: I=1 in HIGH reloads cnt←HIGH_CYC-1 and does not touch pending, so the assertion extends to HIGH_CYC cycles after the last pulse. Events during GAP still queue normally.
  - Undefined: queuing behaviour as in Operation for all states.

## Test plan
All scenarios use default parameters unless stated.
- Reset: rst=0 with I toggling → Y=0, busy=0, pending=0, ovf=0. Deassert rst and hold I=0 → no change.
- Single pulse at edge 10 → Y=1 after edges 10–13, Y=0 from edge 14; busy falls after edge 16; pending stays 0.
- Pulses at edges 10, 11, 12:
  - pending=1 then 2.
  - Y=1 after edges 10–13, 16–19, 22–25, with 2-cycle lows between.
  - pending reaches 1 at edge 16 and 0 at edge 22.
- Overflow: pulses at edges 10–14 → pending 1, 2, 3, then holds at 3 with ovf=1 after edge 14; exactly 4 assertions follow. Pulse clr_ovf=1 afterwards → ovf=0 next edge.
- Launch-point event: pulse at 10, second pulse exactly at edge 16 (GAP cnt=0, pending=0) → Y=1 after edges 16–19; pending stays 0.
- Reset mid-HIGH with pending=2 → Y inactive immediately, pending=0, no further assertions. With PULSE_STRETCH_RETRIG_EN: pulses at 10 and 12 → one assertion after edges 10–15 (6 cycles), pending=0.
